// File: rtl/vga_zoom_reader.sv
// On-the-fly nearest-neighbour zoom reader: maps VGA pixel coordinates onto a native
// IMG_W x IMG_H framebuffer, centred; optional checkerboard border via CHECKER_BG_EN.
module vga_zoom_reader #(
  parameter int               IMG_W        = 160,
  parameter int               IMG_H        = 120,
  parameter int               H_ACT        = 640,
  parameter int               V_ACT        = 480,
  parameter int               ADDR_W       = 19,
  parameter int               PIX_W        = 8,
  parameter int               RAM_LAT      = 1,
  parameter logic [PIX_W-1:0] BORDER_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        zoom_sel,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_out_valid,
  output logic [1:0]        zoom_active,
  output logic              frame_done
);

  localparam bit          FIT2    = ((IMG_W << 1) <= H_ACT) && ((IMG_H << 1) <= V_ACT);
  localparam bit          FIT4    = ((IMG_W << 2) <= H_ACT) && ((IMG_H << 2) <= V_ACT);
  localparam logic [10:0] IMG_W11 = 11'(IMG_W);
  localparam logic [10:0] IMG_H11 = 11'(IMG_H);
  localparam logic [10:0] H_ACT11 = 11'(H_ACT);
  localparam logic [10:0] V_ACT11 = 11'(V_ACT);
  localparam logic [31:0] IMG_W32 = 32'(IMG_W);
  localparam logic [9:0]  LAST_X  = 10'(H_ACT - 1);
  localparam logic [9:0]  LAST_Y  = 10'(V_ACT - 1);

  // Reserved code and zoom factors that would overflow the active area fall back.
  function automatic logic [1:0] clamp_zoom(input logic [1:0] sel);
    logic [1:0] z;
    z = sel;
    if (z == 2'd3) z = 2'd0;
    if (z == 2'd2 && !FIT4) z = 2'd1;
    if (z == 2'd1 && !FIT2) z = 2'd0;
    return z;
  endfunction

  logic [1:0]        zoom_q, zoom_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              frame_start, in_win, is_last;
  logic [10:0]       px, py, win_w, win_h, x_off, y_off, dx, dy;
  logic [31:0]       addr_full;
  logic [PIX_W-1:0]  border_pix;

  // Sideband delay line, index 0 is stage 1; index RAM_LAT lines up with rd_data.
  // A pixel is "valid" at the output exactly when val_q[RAM_LAT] is set; there is no backpressure.
  logic [RAM_LAT:0] win_q, val_q, last_q;

  always_comb begin
    frame_start = pix_valid && (pix_x == 10'd0) && (pix_y == 10'd0);
    zoom_d      = frame_start ? clamp_zoom(zoom_sel) : zoom_q;
    win_w       = IMG_W11 << zoom_d;
    win_h       = IMG_H11 << zoom_d;
    x_off       = (H_ACT11 - win_w) >> 1;
    y_off       = (V_ACT11 - win_h) >> 1;
    px          = {1'b0, pix_x};
    py          = {1'b0, pix_y};
    in_win      = pix_valid && (px >= x_off) && (px < x_off + win_w)
                            && (py >= y_off) && (py < y_off + win_h);
    dx          = (px - x_off) >> zoom_d;
    dy          = (py - y_off) >> zoom_d;
    addr_full   = 32'(dy) * IMG_W32 + 32'(dx);
    rd_addr_d   = in_win ? addr_full[ADDR_W-1:0] : rd_addr_q;
    is_last     = pix_valid && (pix_x == LAST_X) && (pix_y == LAST_Y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zoom_q    <= '0;
      rd_addr_q <= '0;
      win_q     <= '0;
      val_q     <= '0;
      last_q    <= '0;
    end else begin
      zoom_q    <= zoom_d;
      rd_addr_q <= rd_addr_d;
      win_q     <= {win_q[RAM_LAT-1:0], in_win};
      val_q     <= {val_q[RAM_LAT-1:0], pix_valid};
      last_q    <= {last_q[RAM_LAT-1:0], is_last};
    end
  end

`ifdef CHECKER_BG_EN
  logic [RAM_LAT:0] chk_q;

  always_ff @(posedge clk) begin
    if (reset) chk_q <= '0;
    else       chk_q <= {chk_q[RAM_LAT-1:0], pix_x[3] ^ pix_y[3]};
  end

  always_comb begin
    border_pix = chk_q[RAM_LAT] ? ~BORDER_COLOR : BORDER_COLOR;
  end
`else
  always_comb begin
    border_pix = BORDER_COLOR;
  end
`endif

  always_comb begin
    pix_out = '0;
    if (win_q[RAM_LAT])      pix_out = rd_data;
    else if (val_q[RAM_LAT]) pix_out = border_pix;
  end

  assign rd_addr       = rd_addr_q;
  assign rd_en         = win_q[0];
  assign pix_out_valid = val_q[RAM_LAT];
  assign frame_done    = last_q[RAM_LAT];
  assign zoom_active   = zoom_q;

endmodule

// File: tb/tb_vga_zoom_reader.sv
// Randomised scoreboard bench for vga_zoom_reader (default parameters, RAM_LAT=1,
// RAM model returns addr[7:0]).
module tb_vga_zoom_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  zoom_sel = '0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        pix_valid = 1'b0;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data = '0;
  logic [7:0]  pix_out;
  logic        pix_out_valid;
  logic [1:0]  zoom_active;
  logic        frame_done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Expected rd-side entry: {zoom_active, rd_en, rd_addr}; output entry: {frame_done, valid, pix}
  logic [21:0] rd_exp_q[$];
  int          rd_due_q[$];
  logic [9:0]  out_exp_q[$];
  int          out_due_q[$];

  // Reference-model state
  int          m_zoom = 0;
  logic [18:0] m_addr = '0;

  vga_zoom_reader dut (
    .clk(clk), .reset(reset), .zoom_sel(zoom_sel), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .zoom_active(zoom_active),
    .frame_done(frame_done)
  );

  // Clock / reset block and framebuffer model (one clock read latency)
  always #20 clk = ~clk;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= rd_addr[7:0];
  end

  function automatic int eff_zoom(input int sel);
    int z;
    z = (sel == 3) ? 0 : sel;
    if (z == 2 && (160 * 4 > 640 || 120 * 4 > 480)) z = 1;
    if (z == 1 && (160 * 2 > 640 || 120 * 2 > 480)) z = 0;
    return z;
  endfunction

  function automatic logic [7:0] border_of(input int x, input int y);
`ifdef CHECKER_BG_EN
    return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  // Driver: one pixel per clock, expected responses pushed with their due cycle
  task automatic drive(input int x, input int y, input bit v, input int sel);
    int scale, w, h, xo, yo, k;
    bit win;
    logic [7:0] pix;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = v;
    zoom_sel  = 2'(sel);
    k = cyc;
    if (v && x == 0 && y == 0) m_zoom = eff_zoom(sel);
    scale = 1 << m_zoom;
    w  = 160 * scale;
    h  = 120 * scale;
    xo = (640 - w) / 2;
    yo = (480 - h) / 2;
    win = v && x >= xo && x < xo + w && y >= yo && y < yo + h;
    if (win) m_addr = 19'(((y - yo) / scale) * 160 + (x - xo) / scale);
    rd_exp_q.push_back({2'(m_zoom), win, m_addr});
    rd_due_q.push_back(k + 1);
    pix = win ? m_addr[7:0] : (v ? border_of(x, y) : 8'h00);
    out_exp_q.push_back({(v && x == 639 && y == 479), v, pix});
    out_due_q.push_back(k + 2);
  endtask

  // Reset held for one clock while a pixel is presented; in-flight results are discarded
  task automatic reset_cycle(input int x, input int y);
    int k;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = 1'b1;
    zoom_sel  = 2'($urandom_range(0, 3));
    k = cyc;
    while (rd_due_q.size() > 0 && rd_due_q[rd_due_q.size()-1] >= k + 1) begin
      void'(rd_due_q.pop_back());
      void'(rd_exp_q.pop_back());
    end
    while (out_due_q.size() > 0 && out_due_q[out_due_q.size()-1] >= k + 1) begin
      void'(out_due_q.pop_back());
      void'(out_exp_q.pop_back());
    end
    m_zoom = 0;
    m_addr = '0;
    rd_exp_q.push_back('0);
    rd_due_q.push_back(k + 1);
    out_exp_q.push_back('0);
    out_due_q.push_back(k + 1);
    out_exp_q.push_back('0);
    out_due_q.push_back(k + 2);
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    logic [21:0] re;
    logic [9:0]  oe;
    while (rd_due_q.size() > 0 && rd_due_q[0] == cyc) begin
      re = rd_exp_q.pop_front();
      void'(rd_due_q.pop_front());
      checks++;
      if ({zoom_active, rd_en, rd_addr} !== re) begin
        errors++;
        $display("FAIL rd_side cyc=%0d got zoom=%0d en=%0b addr=%0d, expected zoom=%0d en=%0b addr=%0d",
                 cyc, zoom_active, rd_en, rd_addr, re[21:20], re[19], re[18:0]);
      end
    end
    while (out_due_q.size() > 0 && out_due_q[0] == cyc) begin
      oe = out_exp_q.pop_front();
      void'(out_due_q.pop_front());
      checks++;
      if ({frame_done, pix_out_valid, pix_out} !== oe) begin
        errors++;
        $display("FAIL pix_out cyc=%0d got done=%0b valid=%0b pix=%02h, expected done=%0b valid=%0b pix=%02h",
                 cyc, frame_done, pix_out_valid, pix_out, oe[9], oe[8], oe[7:0]);
      end
    end
  end

  initial begin
    int r;
    repeat (3) reset_cycle(0, 0);

    // 1x frame: window corners
    drive(0, 0, 1, 0);
    drive(240, 180, 1, 0);
    drive(399, 299, 1, 0);
    drive(400, 300, 1, 0);
    drive(239, 180, 1, 0);
    // Mid-frame zoom request is ignored until the next frame start
    drive(0, 100, 1, 2);
    drive(240, 180, 1, 2);
    drive(0, 0, 0, 2);
    drive(400, 300, 1, 2);
    // 2x frame
    drive(0, 0, 1, 1);
    drive(160, 120, 1, 1);
    drive(161, 121, 1, 1);
    drive(162, 122, 1, 1);
    drive(159, 120, 1, 1);
    drive(479, 359, 1, 1);
    // 4x frame and frame end
    drive(0, 0, 1, 2);
    drive(4, 4, 1, 2);
    drive(8, 0, 1, 2);
    drive(639, 479, 1, 2);
    drive(639, 479, 0, 2);
    // Reserved zoom code
    drive(0, 0, 1, 3);
    drive(240, 180, 1, 3);
    // Checkerboard / border pixels in 1x
    drive(0, 0, 1, 0);
    drive(8, 0, 1, 0);
    drive(8, 8, 1, 0);
    // Reset mid-frame in 2x
    drive(0, 0, 1, 1);
    drive(200, 150, 1, 1);
    reset_cycle(300, 200);
    drive(240, 180, 1, 1);
    drive(399, 299, 1, 1);
    // Reset together with a frame-start pixel
    reset_cycle(0, 0);
    drive(5, 5, 1, 2);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 29);
      if (r == 0)      drive(0, 0, 1, $urandom_range(0, 3));
      else if (r == 1) drive(639, 479, $urandom_range(0, 1), $urandom_range(0, 3));
      else if (r == 2) reset_cycle($urandom_range(0, 639), $urandom_range(0, 479));
      else             drive($urandom_range(0, 639), $urandom_range(0, 479),
                             ($urandom_range(0, 7) != 0), $urandom_range(0, 3));
    end

    repeat (4) drive(0, 0, 0, 0);
    repeat (4) @(posedge clk);
    if (rd_exp_q.size() != 0 || out_exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending rd=%0d out=%0d, expected 0 and 0", rd_exp_q.size(), out_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
